// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: control-priority encoding, default
// vectors and the priority resolver used by the next-PC mux.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    EXC    = 3'd0,
    HOLD   = 3'd1,
    RET    = 3'd2,
    CALL   = 3'd3,
    BRANCH = 3'd4,
    SEQ    = 3'd5
  } ctl_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

  function automatic ctl_e sel_ctl(input logic exc, input logic stall, input logic ret,
                                   input logic call, input logic branch);
    ctl_e c;
    if (exc) begin
      c = EXC;
    end else if (stall) begin
      c = HOLD;
    end else if (ret) begin
      c = RET;
    end else if (call) begin
      c = CALL;
    end else if (branch) begin
      c = BRANCH;
    end else begin
      c = SEQ;
    end
    return c;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack. Pushing into a full stack overwrites the
// oldest entry; popping an empty stack is reported but changes nothing.
module ras_stack
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // r_ptr is the next write slot; when full it also addresses the oldest entry
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_top_idx;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_top_idx = r_ptr - PTR_ONE;
  assign empty     = (r_cnt == {CW{1'b0}});
  assign full      = (r_cnt == CNT_MAX);
  assign top       = r_mem[w_top_idx];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & ~pop;
  assign overflow  = w_do_push & full;
  assign underflow = pop & empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= {PW{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (w_do_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CNT_ONE;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PTR_ONE;
      if (!full) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  // Entry storage; contents are never read while the stack is empty
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority next-PC mux (exc, stall, ret, call,
// branch, sequential) around a PC register and a return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             exc,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  ctl_e             w_ctl;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_link;
  logic [WIDTH-1:0] w_ret_addr;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_ovf;
  logic             w_unf;
  logic             r_ras_err;

  assign w_ctl  = sel_ctl(exc, stall, ret, call, branch);
  assign w_link = r_pc + WIDTH'(INC);

  // Next-PC selection and stack requests
  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    case (w_ctl)
      EXC:     w_pc_next = EXC_VECTOR;
      HOLD:    w_pc_next = r_pc;
      RET: begin
        w_pop     = 1'b1;
        w_pc_next = w_empty ? target : w_ret_addr;
      end
      CALL: begin
        w_push    = 1'b1;
        w_pc_next = target;
      end
      BRANCH:  w_pc_next = target;
      SEQ:     w_pc_next = w_link;
      default: w_pc_next = r_pc;
    endcase
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_link),
    .top       (w_ret_addr),
    .empty     (w_empty),
    .full      (w_full),
    .overflow  (w_ovf),
    .underflow (w_unf)
  );

  // PC register and sticky stack-error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_VECTOR;
      r_ras_err <= 1'b0;
    end else begin
      r_pc      <= w_pc_next;
      r_ras_err <= r_ras_err | w_ovf | w_unf;
    end
  end

  assign pc        = r_pc;
  assign pc_next   = w_pc_next;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_err   = r_ras_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a 32-bit and an 8-bit instance share the
// same controls; a queue-based reference model predicts both.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc, branch, call, ret;
  logic [31:0] target;
  logic [31:0] pc, pc_next;
  logic        ras_empty, ras_full, ras_err;
  logic [7:0]  pc8, pc_next8;
  logic        ras_empty8, ras_full8, ras_err8;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .exc(exc), .branch(branch),
    .call(call), .ret(ret), .target(target), .pc(pc), .pc_next(pc_next),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  pc_sequencer #(
    .WIDTH(8), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80), .INC(4), .RAS_DEPTH(4)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .exc(exc), .branch(branch),
    .call(call), .ret(ret), .target(target[7:0]), .pc(pc8), .pc_next(pc_next8),
    .ras_empty(ras_empty8), .ras_full(ras_full8), .ras_err(ras_err8)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        err;
  } exp_t;

  exp_t        q_st[$];
  logic [31:0] q_nxt[$];
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_err;
  int          errors = 0;
  int          checks = 0;
  exp_t        mon_st;
  logic [31:0] mon_nxt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".pc"},    pc, 32'h0);
    chk({tag, ".pc8"},   {24'h0, pc8}, 32'h0);
    chk({tag, ".empty"}, {31'h0, ras_empty}, 32'h1);
    chk({tag, ".full"},  {31'h0, ras_full}, 32'h0);
    chk({tag, ".err"},   {31'h0, ras_err}, 32'h0);
    chk({tag, ".err8"},  {31'h0, ras_err8}, 32'h0);
  endtask

  // One cycle of stimulus: drive at the falling edge, predict, queue expectations
  task automatic step(input logic e, input logic s, input logic b, input logic c,
                      input logic r, input logic [31:0] t);
    logic [31:0] np;
    logic [31:0] junk;
    @(negedge clk);
    exc = e; stall = s; branch = b; call = c; ret = r; target = t;
    #1;
    if (e) np = 32'h80;
    else if (s) np = m_pc;
    else if (r) begin
      if (m_stk.size() > 0) np = m_stk.pop_back();
      else begin np = t; m_err = 1'b1; end
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin junk = m_stk.pop_front(); m_err = 1'b1; end
      m_stk.push_back(m_pc + 32'd4);
      np = t;
    end else if (b) np = t;
    else np = m_pc + 32'd4;
    m_pc = np;
    q_nxt.push_back(np);
    q_st.push_back('{pc: np, empty: (m_stk.size() == 0), full: (m_stk.size() == DEPTH), err: m_err});
  endtask

  // Combinational next-PC monitor
  initial forever begin
    @(negedge clk);
    #2;
    if (q_nxt.size() > 0) begin
      mon_nxt = q_nxt.pop_front();
      chk("pc_next", pc_next, mon_nxt);
      chk("pc_next8", {24'h0, pc_next8}, mon_nxt & 32'hFF);
    end
  end

  // Registered-state monitor after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (q_st.size() > 0) begin
      mon_st = q_st.pop_front();
      chk("pc", pc, mon_st.pc);
      chk("pc8", {24'h0, pc8}, mon_st.pc & 32'hFF);
      chk("ras_empty", {31'h0, ras_empty}, {31'h0, mon_st.empty});
      chk("ras_full", {31'h0, ras_full}, {31'h0, mon_st.full});
      chk("ras_err", {31'h0, ras_err}, {31'h0, mon_st.err});
      chk("ras_full8", {31'h0, ras_full8}, {31'h0, mon_st.full});
      chk("ras_empty8", {31'h0, ras_empty8}, {31'h0, mon_st.empty});
      chk("ras_err8", {31'h0, ras_err8}, {31'h0, mon_st.err});
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; exc = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    target = 32'h0;
    model_reset();
    #3;
    check_reset("por");
    @(posedge clk); #2; rst_n = 1'b1;

    // idle from reset
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // call then return
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    // five calls overflow a four-deep stack, five returns underflow it
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
    for (int k = 2; k <= 6; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10 * k);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF00);
    // stall beats branch, exception beats stall
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // wrap-around at both widths; call at 0xFC links 0x00 on the 8-bit unit
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFC);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // simultaneous call and ret acts as ret
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h700);

    // asynchronous reset in the middle of a call cycle
    @(negedge clk);
    call = 1'b1; target = 32'h300;
    #2; rst_n = 1'b0;
    #1; check_reset("mid_reset");
    model_reset();
    @(posedge clk); #1;
    check_reset("held_reset");
    call = 1'b0; target = 32'h0;
    #1; rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), t);
    end

    @(negedge clk);
    exc = 1'b0; stall = 1'b1; branch = 1'b0; call = 1'b0; ret = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("drained", q_st.size() + q_nxt.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded at reset.
REQ-003 Parameter EXC_VECTOR, default 32'h80, PC value loaded on exception.
REQ-004 Parameter INC, default 4, sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two, at least 2.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 stall  input  1  hold PC; blocks sequential, branch, call and ret.
REQ-009 exc  input  1  exception request; overrides stall.
REQ-010 branch  input  1  taken branch/jump to target.
REQ-011 call  input  1  jump to target and push pc+INC.
REQ-012 ret  input  1  pop stack and jump to popped address.
REQ-013 target  input  WIDTH  destination for branch/call, fallback for ret on empty stack.
REQ-014 pc  output  WIDTH  current PC, registered.
REQ-015 pc_next  output  WIDTH  value pc takes at next edge, combinational.
REQ-016 ras_empty  output  1  stack holds zero entries.
REQ-017 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-018 ras_err  output  1  sticky flag: overflow or underflow occurred since reset.

Function
REQ-019 Priority, highest first, SHALL be: exc, stall, ret, call, branch, sequential.
REQ-020 exc=1 SHALL load pc with EXC_VECTOR regardless of stall; stack unchanged.
REQ-021 stall=1 with exc=0 SHALL hold pc and stack unchanged; ret/call/branch ignored.
REQ-022 ret with non-empty stack SHALL load pc with top entry and decrement count.
REQ-023 ret with empty stack SHALL load pc with target, set ras_err, leave count at 0.
REQ-024 call SHALL load pc with target and push pc+INC (modulo 2^WIDTH).
REQ-025 call with full stack SHALL overwrite the oldest entry (circular), hold count at RAS_DEPTH, set ras_err.
REQ-026 branch SHALL load pc with target; stack unchanged.
REQ-027 No control asserted SHALL load pc with pc+INC, wrapping modulo 2^WIDTH.
REQ-028 Simultaneous call and ret SHALL behave as ret only (no push).
REQ-029 pc_next SHALL equal the value pc holds after the next rising edge under current inputs; zero-cycle latency from inputs to pc_next, one cycle to pc.
REQ-030 Stack SHALL be a circular buffer with top pointer and count of width clog2(RAS_DEPTH)+1.
REQ-031 ras_empty/ras_full SHALL be decoded from count, registered-state only.
REQ-032 ras_err SHALL clear only on reset.

Reset
REQ-033 rst_n low SHALL immediately force pc=RESET_VECTOR, count=0, top pointer=0, ras_err=0, independent of clk.
REQ-034 Stack entry contents SHALL NOT require reset; an empty stack is never read.
REQ-035 Reset asserted mid-operation SHALL discard all pending controls; first edge after release SHALL follow REQ-019 from pc=RESET_VECTOR.

Structure
REQ-036 Shared package SHALL hold the control-priority encoding (enum EXC, HOLD, RET, CALL, BRANCH, SEQ) and default RESET_VECTOR/EXC_VECTOR constants.
REQ-037 Return-address stack SHALL be a sub-module ras_stack (push, pop, top, empty, full, overflow, underflow); PC register and priority mux stay in pc_sequencer.

Verification
REQ-038 Reset then 3 idle cycles -> pc 0, 4, 8, 12; ras_empty=1, ras_err=0.
REQ-039 pc=0x100, call target=0x400; next cycle ret -> pc 0x400 then 0x104; ras_empty=1 after ret.
REQ-040 RAS_DEPTH=4, five calls from pc=0x10,0x20,0x30,0x40,0x50 -> ras_full=1, ras_err=1; five rets with target=0xF00 return 0x54,0x44,0x34,0x24 then 0xF00.
REQ-041 stall=1 with branch target=0x200 for 2 cycles -> pc held; stall=1 with exc=1 -> pc=0x80 next cycle.
REQ-042 WIDTH=8, pc=0xFC, idle -> pc=0x00; call at 0xFC pushes 0x00.
REQ-043 rst_n pulled low between clock edges during call -> pc=RESET_VECTOR immediately, count=0, ras_err=0.
